// File: rtl/tt_uart_pkg.sv
// rtl/tt_uart_pkg.sv - shared UART frame format constants and receiver state encoding
package tt_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    // Frame format shared by the receiver, the core and any future transmitter
    localparam int UART_CLK_DIV   = 4;
    localparam int UART_OS        = 16;
    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/tt_uart_rx_if.sv
// rtl/tt_uart_rx_if.sv - received-byte valid/ready handshake between receiver and core
interface tt_uart_rx_if
    import tt_uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/tt_sync2.sv
// rtl/tt_sync2.sv - two-flop synchronizer with configurable reset value
module tt_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_uart_rx.sv
// rtl/tt_uart_rx.sv - 8N1 oversampling serial receiver feeding the core over valid/ready
module tt_uart_rx
    import tt_uart_pkg::*;
#(
    parameter int CLK_DIV   = UART_CLK_DIV,
    parameter int OS        = UART_OS,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_pin,
    tt_uart_rx_if.master rx_if,
    output logic         frame_err,
    output logic         overrun,
    input  logic         err_clr,
    output logic         busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TICK_W = $clog2(OS);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] HALF_MAX = TICK_W'(OS / 2 - 1);
    localparam logic [TICK_W-1:0] OS_MAX   = TICK_W'(OS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic                 rx_s;
    logic [DIV_W-1:0]     div_cnt;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 tick;
    logic                 start_go;
    logic                 phase_end;
    logic                 shift_en;
    logic                 deliver;
    logic                 stop_bad;
    logic                 can_load;

    tt_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_pin),
        .q     (rx_s)
    );

    assign tick     = (div_cnt == DIV_MAX);
    assign busy     = (state != IDLE);
    assign can_load = !valid_q || rx_if.rx_ready;

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        phase_end  = 1'b0;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    start_go   = 1'b1;
                end
            end
            START: begin
                // Mid start bit: a high line here was only a glitch
                if (tick && tick_cnt == HALF_MAX) begin
                    phase_end  = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tick_cnt == OS_MAX) begin
                    phase_end = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && tick_cnt == OS_MAX) begin
                    phase_end = 1'b1;
                    if (rx_s) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (start_go || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (start_go || phase_end) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (start_go) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Shifting in from the top leaves the first received bit in bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;

            if (deliver && can_load) begin
                data_q  <= shift_reg;
                valid_q <= 1'b1;
            end else if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end

            // A drop in the same cycle as err_clr keeps the flag set
            if (deliver && !can_load) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/tt_uart_rx.md
Name: tt_uart_rx

Overview:
- Serial receive front end that sits directly upstream of the tt_um_killer_ core logic.
- Samples the asynchronous serial line on ui_in[0], which is the tile's dedicated input pin.
- Deframes 8N1 characters and hands each byte to the core over a valid/ready handshake.
- Reports framing errors and overruns so the core can expose them on uo_out.

Parameters:
- CLK_DIV, default 4: clock cycles per oversample tick. Legal range is 2 or more.
- OS, default 16: oversample ticks per bit. Must be even and at least 4.
- DATA_BITS, default 8: data bits per frame, sent LSB first.

Ports:
- clk  in  1  design clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_pin  in  1  raw serial line. It is asynchronous to clk and idles high.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  the core accepts the byte.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  sticky flag: a byte was dropped because the holding register was full.
- err_clr  in  1  synchronous clear of overrun.
- busy  out  1  the state machine is not in IDLE.

Behaviour:
- Reset is asynchronous and active-low. Clock is clk, reset is rst_n, and there is only one clock.
- Reset values:
  - Both synchronizer flops = 1.
  - state = IDLE.
  - rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - All counters = 0.
- rx_pin passes through a 2-flop synchronizer to give rx_s. The synchronizer adds 2 cycles of latency.
- Tick generator:
  - Counter runs 0 to CLK_DIV-1 and emits tick when it reaches CLK_DIV-1.
  - It is forced to 0 on the IDLE to START transition, so bit sampling is aligned to the start edge.
- State machine, one-hot or encoded:
  - IDLE: when rx_s = 0 in cycle T, go to START and clear the tick and sample counters.
  - START: after OS/2 ticks, sample rx_s.
    - If 0: go to DATA with bit_cnt = 0.
    - If 1: treat as a glitch and return to IDLE. No output, no error.
  - DATA: every OS ticks, sample rx_s into shift register bit bit_cnt (LSB first). After DATA_BITS samples, go to STOP.
  - STOP: after OS ticks, sample rx_s.
    - If 1: deliver the byte and go to IDLE.
    - If 0: pulse frame_err for 1 cycle, discard the byte, and go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Stop-bit sample point = T + CLK_DIV*(OS/2 + (DATA_BITS+1)*OS). With defaults this is T+608.
- rx_valid rises on the following cycle (T+609). Total latency from the pin edge is therefore about 611 cycles.
- Delivery:
  - If rx_valid = 0, or (rx_valid and rx_ready) in the same cycle: load rx_data and set rx_valid = 1.
  - Otherwise: keep the old byte, drop the new one, and set overrun = 1.
- Handshake:
  - rx_valid falls the cycle after rx_valid and rx_ready, unless a new byte is delivered in that same cycle.
  - rx_data is stable while rx_valid = 1 and rx_ready = 0.
- Simultaneous overrun set and err_clr: set wins.
- busy = (state != IDLE).
- Reset asserted mid-frame aborts immediately. After release, the block waits for a fresh falling edge.

Decomposition:
- Shared package tt_uart_pkg holds:
  - The state enum: IDLE, START, DATA, STOP, BREAK.
  - Default constants for CLK_DIV, OS and DATA_BITS, so the core and a future transmitter agree on the frame format.
- One natural sub-module: tt_sync2. It is a 2-flop synchronizer with a reset value parameter (1 here) and will be reused for the other ui_in pins.

Test Plan:
- Send 0xA5 at 64 cycles/bit with rx_ready = 1 -> rx_valid pulses for 1 cycle with rx_data = 0xA5, about 611 cycles after the start edge. frame_err = 0 and overrun = 0.
- Send 0x3C then 0xC3 back to back with rx_ready = 0 -> 0x3C is held and overrun = 1 after the second stop bit. Raise rx_ready -> 0x3C is consumed and rx_valid = 0. Pulse err_clr -> overrun = 0.
- Send a 20-cycle low glitch on idle rx_pin -> no rx_valid, no frame_err, and busy returns to 0 about 34 cycles after the glitch starts.
- Send 0x55 with the stop bit forced low, then hold the line low for 200 cycles -> one frame_err pulse, no rx_valid, and busy stays 1 until the line goes high. A following 0x0F is then received correctly.
- Assert rst_n low at bit 4 of 0xFF, release, then send 0x81 -> only 0x81 is delivered, with no partial byte.
- Deliver 0x12 and assert rx_ready in the exact cycle the next byte 0x34 is delivered -> 0x12 is consumed, rx_data = 0x34 and rx_valid stays 1 with no gap, overrun = 0.
